// File: rtl/mfrc522_pkg.sv
// Shared definitions for the MFRC522 burst SPI interface.
// Contents: controller state encoding, MFRC522 register addresses used by
// the host firmware, and the SPI address-byte helper.
package mfrc522_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_SHIFT,
        S_CS_GAP,
        S_DONE
    } state_t;

    localparam logic [5:0] REG_COMMAND    = 6'h01;
    localparam logic [5:0] REG_FIFO_DATA  = 6'h09;
    localparam logic [5:0] REG_FIFO_LEVEL = 6'h0A;

    // MFRC522 address byte: bit7 = 1 for read, address in bits 6:1, bit0 = 0.
    function automatic logic [7:0] addr_byte(input logic is_write, input logic [5:0] addr);
        return {~is_write, addr, 1'b0};
    endfunction

endpackage

// File: rtl/mfrc522_burst_if_shifter.sv
// spi_byte_shifter: shifts one byte out/in, SPI mode 0, MSB first.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   i_load, i_byte   start a byte (accepted only when idle)
//   i_miso           serial input, sampled on SCLK rising edge
//   o_sclk, o_mosi   serial clock (idles low) and serial output
//   o_done           one-cycle pulse after the 8th falling edge
//   o_rx_valid       one-cycle pulse when the 8th bit has been sampled
//   o_rx_byte        received byte
module spi_byte_shifter #(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_done,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte
);

    localparam int CW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);

    logic          r_busy;
    logic          r_sclk;
    logic          r_done;
    logic          r_rx_valid;
    logic [CW-1:0] r_half_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_half_cnt <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            if (!r_busy) begin
                // MSB is on MOSI from the load onwards, well before the first rise.
                if (i_load) begin
                    r_busy     <= 1'b1;
                    r_tx       <= i_byte;
                    r_half_cnt <= HALF_LAST;
                    r_bit      <= '0;
                end
            end else if (r_half_cnt != '0) begin
                r_half_cnt <= r_half_cnt - CW'(1);
            end else begin
                r_half_cnt <= HALF_LAST;
                if (!r_sclk) begin
                    r_sclk     <= 1'b1;
                    r_rx       <= {r_rx[6:0], i_miso};
                    r_rx_valid <= (r_bit == 3'd7);
                end else begin
                    r_sclk <= 1'b0;
                    r_bit  <= r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign o_sclk     = r_sclk;
    assign o_mosi     = r_tx[7];
    assign o_done     = r_done;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_byte  = r_rx;

endmodule

// File: rtl/mfrc522_burst_if.sv
// MFRC522 burst register access over SPI mode 0.
// One command = address byte plus 1..MAX_BURST data bytes under a single
// chip-select assertion, followed by a guaranteed chip-select high gap.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_is_write, cmd_addr, cmd_len   command fields (captured at acceptance)
//   wr_data/wr_valid/wr_ready         write byte stream
//   rd_data/rd_valid                  read byte stream (no backpressure)
//   cmd_done, cmd_err                 completion / rejection pulses
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso   SPI bus
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// CHECK    | length validated, CS asserted if valid
// LOAD     | pick next byte (address / write data / read filler)
// SHIFT    | byte in flight in the shifter
// CS_GAP   | CS high, counting the inactive time
// DONE     | cmd_done pulse
module mfrc522_burst_if
    import mfrc522_pkg::*;
#(
    parameter int  CLKS_PER_HALF_BIT = 2,
    parameter int  MAX_BURST         = 64,
    parameter int  CS_INACTIVE_CLKS  = 10,
    localparam int LEN_W             = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_is_write,
    input  logic [5:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int GW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [GW-1:0]  GAP_LAST = GW'(CS_INACTIVE_CLKS - 1);
    localparam logic [LEN_W:0] REM_ONE  = (LEN_W + 1)'(1);

    state_t         r_state;
    logic           r_is_write;
    logic [5:0]     r_addr;
    logic           r_len_bad;
    logic [LEN_W:0] r_remain;     // bytes still to be loaded, address included
    logic           r_first;      // address byte in flight / pending
    logic [GW-1:0]  r_gap_cnt;
    logic           r_cmd_ready;
    logic           r_cmd_done;
    logic           r_cmd_err;
    logic           r_rd_valid;
    logic [7:0]     r_rd_data;
    logic           r_cs_n;
    logic           r_sh_load;
    logic [7:0]     r_sh_byte;

    logic           w_len_bad;
    logic           w_take_wr;
    logic           w_load_ok;
    logic [7:0]     w_next_byte;
    logic           w_sh_done;
    logic           w_sh_rx_valid;
    logic [7:0]     w_sh_rx_byte;

    assign w_len_bad = (cmd_len == '0) || (int'(cmd_len) > MAX_BURST);
    assign w_take_wr = (r_state == S_LOAD) && r_is_write && !r_first && wr_valid;
    assign w_load_ok = (r_state == S_LOAD) && (!r_is_write || r_first || wr_valid);

    // Read bursts repeat the address to clock data out; the final byte is 00.
    always_comb begin
        w_next_byte = addr_byte(r_is_write, r_addr);
        if (!r_first) begin
            if (r_is_write)
                w_next_byte = wr_data;
            else if (r_remain == REM_ONE)
                w_next_byte = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_len_bad   <= 1'b0;
            r_remain    <= '0;
            r_first     <= 1'b0;
            r_gap_cnt   <= '0;
            r_cmd_ready <= 1'b1;
            r_cmd_done  <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_cs_n      <= 1'b1;
            r_sh_load   <= 1'b0;
            r_sh_byte   <= '0;
        end else begin
            r_cmd_done <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_sh_load  <= 1'b0;

            // Read data from the first MISO byte is the MFRC522's dummy response.
            if (w_sh_rx_valid && !r_first && !r_is_write) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= w_sh_rx_byte;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_is_write  <= cmd_is_write;
                        r_addr      <= cmd_addr;
                        r_len_bad   <= w_len_bad;
                        r_cmd_err   <= w_len_bad;
                        r_remain    <= {1'b0, cmd_len} + REM_ONE;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_len_bad) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cs_n  <= 1'b0;
                        r_first <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_load_ok) begin
                        r_sh_load <= 1'b1;
                        r_sh_byte <= w_next_byte;
                        r_remain  <= r_remain - REM_ONE;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_sh_done) begin
                        r_first <= 1'b0;
                        if (r_remain == '0) begin
                            r_cs_n    <= 1'b1;
                            r_gap_cnt <= GAP_LAST;
                            r_state   <= S_CS_GAP;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_CS_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_cmd_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                    end
                end
                S_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_cs_n      <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    spi_byte_shifter #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_sh_load),
        .i_byte    (r_sh_byte),
        .i_miso    (spi_miso),
        .o_sclk    (spi_sclk),
        .o_mosi    (spi_mosi),
        .o_done    (w_sh_done),
        .o_rx_valid(w_sh_rx_valid),
        .o_rx_byte (w_sh_rx_byte)
    );

    assign cmd_ready = r_cmd_ready;
    assign wr_ready  = w_take_wr;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign cmd_done  = r_cmd_done;
    assign cmd_err   = r_cmd_err;
    assign spi_cs_n  = r_cs_n;

endmodule

// File: tb/tb_mfrc522_burst_if.sv
// Scoreboard bench for mfrc522_burst_if: expected MOSI bytes and read data
// are queued when a command is issued and popped as the SPI slave model and
// the read stream produce them.
module tb_mfrc522_burst_if;

    localparam int CPH   = 2;
    localparam int MAXB  = 64;
    localparam int CSG   = 10;
    localparam int LEN_W = $clog2(MAXB + 1);
    localparam int STALL_CYC = 52;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_is_write = 1'b0;
    logic [5:0]       cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [7:0]       wr_data = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             cmd_done;
    logic             cmd_err;
    logic             spi_cs_n;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso = 1'b0;

    always #5 clk = ~clk;

    mfrc522_burst_if #(
        .CLKS_PER_HALF_BIT(CPH),
        .MAX_BURST        (MAXB),
        .CS_INACTIVE_CLKS (CSG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_is_write(cmd_is_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .cmd_done    (cmd_done),
        .cmd_err     (cmd_err),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] miso_src[$];
    logic [7:0] wr_src[$];
    logic [7:0] cmd_data[$];

    int sclk_rises = 0, done_cnt = 0, err_cnt = 0, cs_low_cnt = 0, cs_rise_cnt = 0;
    int rdv_cnt = 0, hs_cnt = 0, mo_bit = 0, mo_bytes = 0;
    int stall_at_hs = -1;

    // SPI slave model and output monitor, sampled mid-cycle.
    initial begin
        logic [7:0] mo_sh;
        logic [7:0] m_tx;
        int         m_bit;
        logic       prev_cs;
        logic       prev_sclk;
        mo_sh = '0; m_tx = '0; m_bit = 0; prev_cs = 1'b1; prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!spi_cs_n && prev_cs) begin
                m_bit    = 0;
                m_tx     = (miso_src.size() != 0) ? miso_src.pop_front() : 8'h00;
                mo_bit   = 0;
                mo_bytes = 0;
            end
            if (spi_cs_n && !prev_cs) begin
                mo_bit = 0;
                cs_rise_cnt++;
            end
            if (spi_sclk && !prev_sclk) begin
                sclk_rises++;
                mo_sh = {mo_sh[6:0], spi_mosi};
                mo_bit++;
                if (mo_bit == 8) begin
                    mo_bit = 0;
                    mo_bytes++;
                    check_val("mosi_expected", 32'(exp_mosi.size() != 0), 32'd1);
                    if (exp_mosi.size() != 0)
                        check_val("mosi_byte", 32'(mo_sh), 32'(exp_mosi.pop_front()));
                end
            end
            if (!spi_sclk && prev_sclk) begin
                m_bit++;
                if (m_bit == 8) begin
                    m_bit = 0;
                    m_tx  = (miso_src.size() != 0) ? miso_src.pop_front() : 8'h00;
                end else begin
                    m_tx = {m_tx[6:0], 1'b0};
                end
            end
            spi_miso = m_tx[7];
            if (spi_cs_n === 1'b0) cs_low_cnt++;
            if (rd_valid === 1'b1) begin
                rdv_cnt++;
                check_val("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0)
                    check_val("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
            end
            if (cmd_done === 1'b1) done_cnt++;
            if (cmd_err === 1'b1) err_cnt++;
            if (wr_valid && wr_ready === 1'b1) hs_cnt++;
            prev_cs   = spi_cs_n;
            prev_sclk = spi_sclk;
        end
    end

    // Write stream driver; optional hold of wr_valid after a given handshake.
    initial begin
        int popped;
        int held;
        int armed_for;
        popped = 0; held = 0; armed_for = -1;
        forever begin
            @(posedge clk);
            #1;
            while (popped < hs_cnt) begin
                if (wr_src.size() != 0) void'(wr_src.pop_front());
                popped++;
            end
            if (stall_at_hs != armed_for) begin
                armed_for = stall_at_hs;
                held      = 0;
            end
            if (hs_cnt == stall_at_hs && held < STALL_CYC) begin
                held++;
                wr_valid = 1'b0;
            end else begin
                wr_valid = (wr_src.size() != 0);
                wr_data  = (wr_src.size() != 0) ? wr_src[0] : 8'h00;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic s_valid, s_w;
    int   s_len, s_done, s_err, s_rises, s_hs, s_rdv, s_cslow, s_csrise;

    task automatic fill_data(input int len);
        cmd_data.delete();
        for (int i = 0; i < len; i++) cmd_data.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic issue(input logic w, input logic [5:0] addr, input int len);
        logic [7:0] ab;
        int         t;
        s_valid = (len >= 1 && len <= MAXB);
        s_w = w; s_len = len;
        s_done = done_cnt; s_err = err_cnt; s_rises = sclk_rises; s_hs = hs_cnt;
        s_rdv = rdv_cnt; s_cslow = cs_low_cnt; s_csrise = cs_rise_cnt;
        ab = {~w, addr, 1'b0};
        if (s_valid) begin
            exp_mosi.push_back(ab);
            if (w) begin
                for (int i = 0; i < len; i++) begin
                    exp_mosi.push_back(cmd_data[i]);
                    wr_src.push_back(cmd_data[i]);
                end
            end else begin
                miso_src.push_back(8'hAA);
                for (int i = 0; i < len; i++) begin
                    if (i > 0) exp_mosi.push_back(ab);
                    miso_src.push_back(cmd_data[i]);
                    exp_rd.push_back(cmd_data[i]);
                end
                exp_mosi.push_back(8'h00);
            end
        end
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin tick(); t++; end
        check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_is_write = w; cmd_addr = addr; cmd_len = LEN_W'(len);
        tick();
        cmd_valid = 1'b0; cmd_is_write = ~w; cmd_addr = ~addr; cmd_len = LEN_W'(3);
        check_val("cmd_ready_drop", 32'(cmd_ready), 32'd0);
    endtask

    task automatic complete(input int budget, output int max_low);
        int t;
        int run;
        t = 0; run = 0; max_low = 0;
        while (done_cnt == s_done && err_cnt == s_err && t < budget) begin
            tick();
            t++;
            if (spi_cs_n === 1'b0 && spi_sclk === 1'b0) run++; else run = 0;
            if (run > max_low) max_low = run;
        end
        check_val("finish_in_budget", 32'(t < budget), 32'd1);
        repeat (30) tick();
        if (s_valid) begin
            check_val("done_count", 32'(done_cnt - s_done), 32'd1);
            check_val("err_count", 32'(err_cnt - s_err), 32'd0);
            check_val("sclk_rises", 32'(sclk_rises - s_rises), 32'(8 * (s_len + 1)));
            check_val("cs_rises", 32'(cs_rise_cnt - s_csrise), 32'd1);
            check_val("wr_handshakes", 32'(hs_cnt - s_hs), s_w ? 32'(s_len) : 32'd0);
            check_val("rd_pulses", 32'(rdv_cnt - s_rdv), s_w ? 32'd0 : 32'(s_len));
            check_val("mosi_left", 32'(exp_mosi.size()), 32'd0);
            check_val("rd_left", 32'(exp_rd.size()), 32'd0);
        end else begin
            check_val("bad_err_count", 32'(err_cnt - s_err), 32'd1);
            check_val("bad_done_count", 32'(done_cnt - s_done), 32'd0);
            check_val("bad_cs_low", 32'(cs_low_cnt - s_cslow), 32'd0);
            check_val("bad_sclk", 32'(sclk_rises - s_rises), 32'd0);
        end
        check_val("ready_after", 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_cs_n"}, 32'(spi_cs_n), 32'd1);
        check_val({pfx, "_sclk"}, 32'(spi_sclk), 32'd0);
        check_val({pfx, "_mosi"}, 32'(spi_mosi), 32'd0);
        check_val({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_val({pfx, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check_val({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check_val({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
        check_val({pfx, "_cmd_done"}, 32'(cmd_done), 32'd0);
        check_val({pfx, "_cmd_err"}, 32'(cmd_err), 32'd0);
    endtask

    initial begin
        int ml;
        int t;
        int d0;

        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (3) tick();

        // Single-byte write to CommandReg.
        cmd_data.delete(); cmd_data.push_back(8'h0F);
        issue(1'b1, 6'h01, 1);
        complete(400, ml);

        // Read FIFODataReg, three bytes.
        cmd_data.delete();
        cmd_data.push_back(8'h11); cmd_data.push_back(8'h22); cmd_data.push_back(8'h33);
        issue(1'b0, 6'h09, 3);
        complete(600, ml);

        // Assorted short bursts.
        fill_data(2);
        issue(1'b1, 6'h0A, 2);
        complete(500, ml);
        fill_data(1);
        issue(1'b0, 6'h2C, 1);
        complete(400, ml);

        // Write with wr_valid withheld before the third data byte.
        fill_data(4);
        stall_at_hs = hs_cnt + 2;
        issue(1'b1, 6'h09, 4);
        complete(800, ml);
        check_val("stall_low_run", 32'(ml >= 18), 32'd1);
        stall_at_hs = -1;

        // Illegal lengths.
        issue(1'b1, 6'h09, 0);
        complete(100, ml);
        issue(1'b0, 6'h09, MAXB + 1);
        complete(100, ml);

        // Maximum length read.
        fill_data(MAXB);
        issue(1'b0, 6'h09, MAXB);
        complete((MAXB + 1) * 40 + 200, ml);

        // Reset in the middle of the first data byte of a write.
        fill_data(3);
        issue(1'b1, 6'h09, 3);
        t = 0;
        while (!(mo_bytes == 1 && mo_bit >= 3 && spi_cs_n === 1'b0) && t < 400) begin
            tick();
            t++;
        end
        check_val("abort_point", 32'(t < 400), 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        exp_mosi.delete(); exp_rd.delete(); miso_src.delete(); wr_src.delete();
        s_rdv = rdv_cnt;
        repeat (60) tick();
        check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("abort_no_rd", 32'(rdv_cnt - s_rdv), 32'd0);

        fill_data(2);
        issue(1'b1, 6'h0A, 2);
        complete(500, ml);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
